sprite_scanline_eval: RTL
=========================

// Module: sprite_scanline_eval
// PURPOSE
//  Per-scanline sprite evaluation stage of the PPU. On each start pulse it scans all 64
//  spriteViewRam entries through the spriteRam eight-RAM read port (addr out, 32b data back,
//  1-cycle registered latency). It keeps the first 8 sprites, in index order, that cover the
//  target line. The line buffer and tile-row fetch stage reads those 8 slots through rd_*.
// PARAMETERS
//  SPRITE_NUM  64   entries scanned per evaluation (addr width = $clog2(SPRITE_NUM))
//  SLOT_NUM    8    max sprites kept per line
//  SPRITE_H    8    sprite height in lines (legal: 8 or 16)
//  HIDE_Y      240  sprites with posY >= HIDE_Y never hit (parking position)
// PORTS
//  clk          in   1   PPU clock (same clock as spriteRam clkEightRam)
//  rstn         in   1   async reset, active low
//  eval_start   in   1   1-cycle pulse: begin evaluation of eval_line
//  eval_line    in   8   target scanline, sampled with eval_start
//  ram_addr     out  6   spriteRam addrReadEightRam
//  ram_data     in   32  spriteRam dataToEightRam: [31:24]posX [23:16]posY [15:8]tile [7:0]attr
//  busy         out  1   evaluation in progress
//  done         out  1   1-cycle pulse: slots valid for eval_line
//  sprite_cnt   out  4   sprites found, 0..8
//  overflow     out  1   more than SLOT_NUM sprites hit eval_line
//  rd_idx       in   3   slot select
//  rd_data      out  32  slot word, unchanged from spriteRam format
//  rd_row       out  4   row inside sprite (eval_line - posY)
//  rd_valid     out  1   rd_idx < sprite_cnt
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, ram_addr=0, busy=0, done=0, sprite_cnt=0, overflow=0.
//   All slot words and rows are cleared to 0, so rd_data=0, rd_row=0, rd_valid=0.
//  FSM: IDLE -> SCAN -> DRAIN -> IDLE.
//   IDLE: eval_start=1 at edge E0 latches the line, clears sprite_cnt/overflow, busy=1,
//    ram_addr=0, state goes to SCAN.
//   SCAN: ram_addr increments by 1 each cycle, 0..63. On the edge where ram_addr=63,
//    the state goes to DRAIN.
//   DRAIN: one cycle to evaluate the data for entry 63. done=1 and busy=0 in the next
//    cycle, and the state returns to IDLE.
//  Pipeline: entry k is presented in cycle k+1 and its data is evaluated at edge E(k+2).
//   done is high in the cycle after E65: a fixed 66-cycle latency regardless of hits.
//  Hit rule: 9-bit compare. Hit iff posY < HIDE_Y, eval_line >= posY and
//   (eval_line - posY) < SPRITE_H. No vertical wrap: posY=250 never covers line 2.
//  On a hit with sprite_cnt < SLOT_NUM: write the word and row to slot[sprite_cnt],
//   then sprite_cnt+1.
//  On a hit with sprite_cnt == SLOT_NUM: set overflow (sticky until next start).
//   Slots are not modified and the scan continues to the fixed end.
//  Slot order = ascending sprite index (index 0 has highest priority).
//  Read port: combinational from the slot registers.
//   rd_valid = (rd_idx < sprite_cnt). Slots >= sprite_cnt read as 0.
//   Slot contents are stable from done until the next accepted eval_start.
//  eval_start while busy: abort and restart at once for the new eval_line.
//   ram_addr=0, sprite_cnt=0, overflow=0, no done for the aborted run.
//   The new run's done arrives 66 cycles after the restart edge.
//  eval_start coincident with done cycle: accepted (state is IDLE); done still pulses once.
//  rstn asserted mid-scan: immediate return to the reset values; no done pulse.
//  Slots are not double-buffered. The consumer must finish reading before the next
//   eval_start; slots clear on start.
// TESTING
//  1 Reset: rstn=0 mid-scan -> busy=0, done=0, sprite_cnt=0, rd_valid=0 the same cycle.
//  2 Single hit: entry 5 = posY 0x10, tile 0x22, posX 0x40; line 0x13 ->
//     done at start+66; cnt=1; slot0={40,10,22,attr}; rd_row=3.
//  3 Bounds (SPRITE_H=8): posY 0x10 hits lines 0x10..0x17, misses 0x0F and 0x18.
//     posY 0xFA at line 2 misses. posY 240 at line 240 misses (hidden).
//  4 Overflow: entries 3,7,9,..(10 hits) on line 50 -> cnt=8, overflow=1;
//     slots hold the 8 lowest indices in order; slot 7 is not overwritten.
//  5 Restart: eval_start at cycle 30 of a scan with line 20 ->
//     one done, 66 cycles after the restart, with results for line 20 only.
//  6 Readback: cnt=3 -> rd_idx 0..2 valid with data; rd_idx 3..7 give rd_valid=0, rd_data=0.

Source files
------------

// File: rtl/sprite_scanline_eval.sv
// sprite_scanline_eval
//   Per-scanline sprite evaluation. A start pulse latches the target line and
//   walks all SPRITE_NUM sprite words through the registered sprite RAM read
//   port. The first SLOT_NUM sprites in index order that cover the line are
//   copied into slot registers along with their row offset. A later hit only
//   sets a sticky overflow flag. The fetch stage reads the slots through a
//   combinational port.
//
//   Ports
//     clk, rstn      clock, async active-low reset
//     eval_start     1-cycle start pulse; restarts a run already in progress
//     eval_line      target scanline, sampled with eval_start
//     ram_addr       sprite RAM read address (1-cycle registered latency)
//     ram_data       sprite word {posX, posY, tile, attr}
//     busy / done    run in progress / 1-cycle completion pulse
//     sprite_cnt     slots filled (0..SLOT_NUM)
//     overflow       more than SLOT_NUM sprites covered the line
//     rd_idx         slot select
//     rd_data/rd_row slot word and row inside the sprite (0 for unused slots)
//     rd_valid       rd_idx < sprite_cnt
module sprite_scanline_eval #(
    parameter int SPRITE_NUM = 64,
    parameter int SLOT_NUM   = 8,
    parameter int SPRITE_H   = 8,
    parameter int HIDE_Y     = 240,
    localparam int AW = $clog2(SPRITE_NUM),
    localparam int CW = $clog2(SLOT_NUM + 1),
    localparam int IW = $clog2(SLOT_NUM)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          eval_start,
    input  logic [7:0]    eval_line,
    output logic [AW-1:0] ram_addr,
    input  logic [31:0]   ram_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sprite_cnt,
    output logic          overflow,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    output logic [3:0]    rd_row,
    output logic          rd_valid
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(SPRITE_NUM - 1);

    state_t      state, state_nxt;
    logic [7:0]  line_q;
    logic        data_vld;   // ram_data holds the word addressed last cycle
    logic [31:0] slot_word [SLOT_NUM];
    logic [3:0]  slot_row  [SLOT_NUM];

    logic [8:0]  pos_y, line9, diff;
    logic        hit;

    // 9-bit compare so a sprite parked near the bottom cannot wrap onto
    // the top lines.
    assign pos_y = {1'b0, ram_data[23:16]};
    assign line9 = {1'b0, line_q};
    assign diff  = line9 - pos_y;
    assign hit   = (pos_y < 9'(HIDE_Y)) && (line9 >= pos_y) &&
                   (diff < 9'(SPRITE_H));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (eval_start) state_nxt = SCAN;
            SCAN:    if (eval_start) state_nxt = SCAN;
                     else if (ram_addr == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = eval_start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_q     <= '0;
            ram_addr   <= '0;
            data_vld   <= 1'b0;
            done       <= 1'b0;
            sprite_cnt <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < SLOT_NUM; i++) begin
                slot_word[i] <= '0;
                slot_row[i]  <= '0;
            end
        end else begin
            // A start in the drain cycle aborts the run, so it suppresses done.
            done <= (state == DRAIN) && !eval_start;
            if (eval_start) begin
                // Accepted in any state: a run in flight is abandoned.
                line_q     <= eval_line;
                ram_addr   <= '0;
                data_vld   <= 1'b0;
                sprite_cnt <= '0;
                overflow   <= 1'b0;
                for (int i = 0; i < SLOT_NUM; i++) begin
                    slot_word[i] <= '0;
                    slot_row[i]  <= '0;
                end
            end else begin
                data_vld <= (state == SCAN);
                // Wraps back to 0 after the last entry, ready for the next run.
                if (state == SCAN) ram_addr <= ram_addr + AW'(1);
                if (data_vld && hit) begin
                    if (sprite_cnt < CW'(SLOT_NUM)) begin
                        slot_word[sprite_cnt[IW-1:0]] <= ram_data;
                        slot_row[sprite_cnt[IW-1:0]]  <= diff[3:0];
                        sprite_cnt <= sprite_cnt + CW'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign rd_valid = (CW'(rd_idx) < sprite_cnt);

    always_comb begin
        rd_data = '0;
        rd_row  = '0;
        if (rd_valid) begin
            rd_data = slot_word[rd_idx];
            rd_row  = slot_row[rd_idx];
        end
    end
endmodule
